alu_decode: RTL and testbench
=============================

ALU_DECODE -- requirements
Module: alu_decode

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  instruction and operands on in_* are valid.
REQ-004 in_ready  output  1  block accepts in_*; a transfer occurs when in_valid && in_ready at a clock edge.
REQ-005 in_instr  input  32  RV32I instruction word.
REQ-006 in_pc  input  32  PC of in_instr (AUIPC only).
REQ-007 in_rs1_val / in_rs2_val  input  32 each  register-file read values.
REQ-008 out_valid  output  1  out_* holds a decoded ALU operation.
REQ-009 out_ready  input  1  consumer accepts; a transfer occurs when out_valid && out_ready at a clock edge.
REQ-010 out_ctrl  output  3  ALU opcode: 0 add, 1 sll, 2 slt, 3 sltu, 4 xor, 5 shift-right, 6 or, 7 and.
REQ-011 out_a / out_b  output  32 each  ALU operands.
REQ-012 out_rd  output  5  destination register, instr[11:7].
REQ-013 out_illegal  output  1  instruction is not a supported ALU-class encoding.

Function
REQ-014 Opcode 0010011 (OP-IMM) SHALL give out_ctrl=funct3, out_a=rs1_val, out_b=sign-extended instr[31:20].
REQ-015 Opcode 0110011 (OP) SHALL give out_ctrl=funct3, out_a=rs1_val, out_b=rs2_val, except:
- SUB (funct7=0100000, funct3=000): out_b = two's complement of rs2_val (~rs2_val+1, mod 2^32).
- SRA (funct7=0100000, funct3=101): out_b = {21'b0, 1'b1, 5'b0, rs2_val[4:0]}.
REQ-016 Shift-right with arithmetic intent SHALL always present out_b[10]=1; logical shifts SHALL present out_b[10]=0.
REQ-017 Opcode 0110111 (LUI) SHALL give out_ctrl=0, out_a=0, out_b={instr[31:12],12'b0}; opcode 0010111 (AUIPC) SHALL give out_ctrl=0, out_a=in_pc, out_b={instr[31:12],12'b0}.
REQ-018 Illegal encodings SHALL set out_illegal=1, out_ctrl=0, out_a=0, out_b=0, out_rd=instr[11:7]. Illegal encodings are: any other opcode; OP with funct7 other than 0000000 (or 0100000 for funct3 000/101); OP-IMM slli/srli/srai with imm[11:5] not in {0000000, 0100000 (101 only)}.
REQ-019 Latency SHALL be exactly one cycle: an accepted input appears on out_* at the next edge when the output register is empty or drains that edge.
REQ-020 out_* SHALL be held stable while out_valid && !out_ready.
REQ-021 Transfers SHALL be in order and lossless; no item is duplicated or dropped under any out_ready pattern.
REQ-022 Simultaneous out transfer and in transfer at the same edge SHALL replace the output register with the new item, with no bubble.
REQ-023 An x0 destination SHALL be passed through unchanged; it is not treated as illegal.

Reset
REQ-024 While rst_n=0: out_valid=0, out_ctrl=0, out_a=0, out_b=0, out_rd=0, out_illegal=0, and the skid entry is empty.
REQ-025 With ALU_DEC_SKID_EN defined, in_ready=0 during reset and goes to 1 on the first edge after deassertion; without it, in_ready follows REQ-029.
REQ-026 Reset asserted mid-transfer SHALL discard all held items.

Configuration
REQ-027 The macro ALU_DEC_SKID_EN SHALL select the ready-path structure.
REQ-028 Defined: a one-entry skid register is added, and in_ready is driven from a flop as !skid_full. A second item accepted while out_valid && !out_ready is parked in the skid entry and moves to out_* when the output drains.
REQ-029 Undefined: no skid entry; in_ready = !out_valid || out_ready (combinational).

Structure
REQ-030 The shared package alu_pkg SHALL hold:
- the 3-bit ALU opcode constants ALU_ADD..ALU_AND (values 0..7);
- the opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC;
- the funct7 constants F7_BASE and F7_ALT.
REQ-031 Pure decode SHALL live in the combinational sub-module alu_dec_comb; alu_decode holds only the handshake, output register and optional skid register.

Verification
REQ-032 ADDI x1,x0,5 (0x00500093), rs1_val=0 -> next cycle out_ctrl=0, out_a=0, out_b=5, out_rd=1, out_illegal=0.
REQ-033 SUB x3,x1,x2 (0x402081B3), rs1_val=10, rs2_val=3 -> out_ctrl=0, out_a=10, out_b=0xFFFFFFFD, out_rd=3.
REQ-034 SRAI x5,x6,4 (0x40435293), rs1_val=0x80000000 -> out_ctrl=5, out_b=0x00000404; LUI x7,0x12345 (0x123453B7) -> out_ctrl=0, out_a=0, out_b=0x12345000.
REQ-035 Opcode 0x0000007F -> out_illegal=1, out_ctrl=0, out_a=0, out_b=0.
REQ-036 Stream of 3 back-to-back ADDI items with out_ready held low for 3 cycles, then high:
- skid build: in_ready drops after the second item is accepted;
- both builds: items emerge in order with no loss and out_* stable while stalled.
REQ-037 rst_n pulsed low for 1 cycle while out_valid=1 -> out_valid=0 immediately (asynchronously); the held item is never delivered.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU-class decoder: ALU opcodes,
// major opcodes, funct7 values and the decoded-operation record.
package alu_pkg;

    // ALU operation selects presented on out_ctrl
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SLL  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_SLTU = 3'd3;
    localparam logic [2:0] ALU_XOR  = 3'd4;
    localparam logic [2:0] ALU_SR   = 3'd5;
    localparam logic [2:0] ALU_OR   = 3'd6;
    localparam logic [2:0] ALU_AND  = 3'd7;

    // RV32I major opcodes handled by the decoder
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 / imm[11:5] values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One decoded ALU operation as held in the output / skid registers
    typedef struct packed {
        logic        illegal;
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } alu_op_t;

    function automatic logic [31:0] sext_imm12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/alu_decode_if.sv
// Valid/ready bundle between the instruction source, the ALU decoder and
// the ALU consumer. The decoder uses the slave view, the environment the
// master view.
interface alu_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_ctrl;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
        output in_ready, out_valid, out_ctrl, out_a, out_b, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
        input  in_ready, out_valid, out_ctrl, out_a, out_b, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_dec_comb.sv
// Pure combinational RV32I ALU-class decode: instruction + operands in,
// ALU opcode, operand pair, destination and illegal flag out.
module alu_dec_comb
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output alu_op_t     op
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Decode the opcode class; illegal encodings collapse to zero operands
    always_comb begin
        op     = '0;
        op.rd  = instr[11:7];
        legal  = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                op.ctrl = funct3;
                op.a    = rs1_val;
                op.b    = sext_imm12(instr[31:20]);
                // srai keeps imm[10]=1 from its encoding, srli/slli keep it 0
                if (funct3 == ALU_SLL)
                    legal = (funct7 == F7_BASE);
                else if (funct3 == ALU_SR)
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                else
                    legal = 1'b1;
            end
            OPC_OP: begin
                op.ctrl = funct3;
                op.a    = rs1_val;
                op.b    = rs2_val;
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    // Bit 10 of out_b flags arithmetic shift; logical shifts clear it
                    if ((funct3 == ALU_SLL) || (funct3 == ALU_SR))
                        op.b[10] = 1'b0;
                end else if ((funct7 == F7_ALT) && (funct3 == ALU_ADD)) begin
                    legal = 1'b1;
                    op.b  = ~rs2_val + 32'd1;
                end else if ((funct7 == F7_ALT) && (funct3 == ALU_SR)) begin
                    legal = 1'b1;
                    op.b  = {21'b0, 1'b1, 5'b0, rs2_val[4:0]};
                end
            end
            OPC_LUI: begin
                legal   = 1'b1;
                op.ctrl = ALU_ADD;
                op.a    = 32'd0;
                op.b    = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                op.ctrl = ALU_ADD;
                op.a    = pc;
                op.b    = {instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            op.ctrl = ALU_ADD;
            op.a    = 32'd0;
            op.b    = 32'd0;
        end
        op.illegal = !legal;
    end

endmodule

// File: rtl/alu_decode.sv
// ALU decode stage: combinational decode into a one-deep valid/ready
// output register. Define ALU_DEC_SKID_EN to add a one-entry skid register
// so in_ready comes straight from a flop instead of from out_ready.
module alu_decode
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    alu_decode_if.slave  bus
);

    alu_op_t dec_p0;
    alu_op_t dec_p1;
    logic    vld_p1;
    logic    vld_nxt;
    logic    load_out_new;
    logic    in_fire;
    logic    out_fire;

    alu_dec_comb u_dec (
        .instr   (bus.in_instr),
        .pc      (bus.in_pc),
        .rs1_val (bus.in_rs1_val),
        .rs2_val (bus.in_rs2_val),
        .op      (dec_p0)
    );

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = vld_p1 && bus.out_ready;

`ifdef ALU_DEC_SKID_EN
    alu_op_t skid_p1;
    logic    skid_vld;
    logic    skid_vld_nxt;
    logic    load_out_skid;
    logic    load_skid;
    logic    rdy_q;

    assign bus.in_ready = rdy_q;

    // Route each accepted item to the output register or park it in the skid entry
    always_comb begin
        load_out_skid = skid_vld && out_fire;
        load_out_new  = !skid_vld && in_fire && (!vld_p1 || out_fire);
        load_skid     = !skid_vld && in_fire && vld_p1 && !out_fire;
        vld_nxt       = load_out_skid || load_out_new || (vld_p1 && !out_fire);
        skid_vld_nxt  = load_skid || (skid_vld && !out_fire);
    end

    // Skid occupancy and registered ready; ready stays low through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_vld <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            skid_vld <= skid_vld_nxt;
            rdy_q    <= !skid_vld_nxt;
        end
    end

    // Skid payload; only meaningful while skid_vld is set
    always_ff @(posedge clk) begin
        if (load_skid)
            skid_p1 <= dec_p0;
    end
`else
    assign bus.in_ready = !vld_p1 || bus.out_ready;

    // Without a skid entry every accepted item goes straight to the output register
    always_comb begin
        load_out_new = in_fire;
        vld_nxt      = in_fire || (vld_p1 && !out_fire);
    end
`endif

    // Output valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld_nxt;
    end

    // ---- stage p1: output register, held while stalled ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_p1 <= '0;
`ifdef ALU_DEC_SKID_EN
        end else if (load_out_skid) begin
            dec_p1 <= skid_p1;
`endif
        end else if (load_out_new) begin
            dec_p1 <= dec_p0;
        end
    end

    assign bus.out_valid   = vld_p1;
    assign bus.out_ctrl    = dec_p1.ctrl;
    assign bus.out_a       = dec_p1.a;
    assign bus.out_b       = dec_p1.b;
    assign bus.out_rd      = dec_p1.rd;
    assign bus.out_illegal = dec_p1.illegal;

endmodule

// File: tb/tb_alu_decode.sv
// Directed self-checking bench for alu_decode. Honors ALU_DEC_SKID_EN when
// the bundle is compiled with it.
module tb_alu_decode;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_decode_if bus ();

    alu_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Observed output word: {valid, illegal, ctrl, a, b, rd}
    logic [73:0] obs;
    assign obs = {bus.out_valid, bus.out_illegal, bus.out_ctrl,
                  bus.out_a, bus.out_b, bus.out_rd};

    function automatic logic [73:0] pk(input logic il, input logic [2:0] c,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] rd);
        return {1'b1, il, c, a, b, rd};
    endfunction

    // Present one item with the consumer ready and step one edge
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid   = 1'b1;
        bus.in_instr   = instr;
        bus.in_pc      = pc;
        bus.in_rs1_val = rs1;
        bus.in_rs2_val = rs2;
        bus.out_ready  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_chk++;
        if (obs !== 74'd0) begin
            $display("FAIL reset_outputs got %h want 0", obs); n_fail++;
        end
        n_chk++;
`ifdef ALU_DEC_SKID_EN
        if (bus.in_ready !== 1'b0) begin
            $display("FAIL reset_in_ready got %b want 0", bus.in_ready); n_fail++;
        end
`else
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready); n_fail++;
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); n_fail++;
        end
    endtask

    task automatic test_addi();
        send(32'h00500093, 32'd0, 32'd0, 32'd0);
        n_chk++;
        if (obs !== pk(1'b0, 3'd0, 32'd0, 32'd5, 5'd1)) begin
            $display("FAIL addi got %h want %h", obs, pk(1'b0, 3'd0, 32'd0, 32'd5, 5'd1)); n_fail++;
        end
        send(32'h00100013, 32'd0, 32'd7, 32'd0);
        n_chk++;
        if (obs !== pk(1'b0, 3'd0, 32'd7, 32'd1, 5'd0)) begin
            $display("FAIL addi_x0 got %h want %h", obs, pk(1'b0, 3'd0, 32'd7, 32'd1, 5'd0)); n_fail++;
        end
    endtask

    task automatic test_op();
        send(32'h402081B3, 32'd0, 32'd10, 32'd3);
        n_chk++;
        if (obs !== pk(1'b0, 3'd0, 32'd10, 32'hFFFFFFFD, 5'd3)) begin
            $display("FAIL sub got %h want %h", obs, pk(1'b0, 3'd0, 32'd10, 32'hFFFFFFFD, 5'd3)); n_fail++;
        end
        send(32'h0020A1B3, 32'd0, 32'h11, 32'h22);
        n_chk++;
        if (obs !== pk(1'b0, 3'd2, 32'h11, 32'h22, 5'd3)) begin
            $display("FAIL slt got %h want %h", obs, pk(1'b0, 3'd2, 32'h11, 32'h22, 5'd3)); n_fail++;
        end
        send(32'h4020D233, 32'd0, 32'h80000000, 32'h23);
        n_chk++;
        if (obs !== pk(1'b0, 3'd5, 32'h80000000, 32'h403, 5'd4)) begin
            $display("FAIL sra got %h want %h", obs, pk(1'b0, 3'd5, 32'h80000000, 32'h403, 5'd4)); n_fail++;
        end
        send(32'h022081B3, 32'd0, 32'd10, 32'd3);
        n_chk++;
        if (obs !== pk(1'b1, 3'd0, 32'd0, 32'd0, 5'd3)) begin
            $display("FAIL op_bad_f7 got %h want %h", obs, pk(1'b1, 3'd0, 32'd0, 32'd0, 5'd3)); n_fail++;
        end
    endtask

    task automatic test_imm_shift();
        send(32'h40435293, 32'd0, 32'h80000000, 32'd0);
        n_chk++;
        if (obs !== pk(1'b0, 3'd5, 32'h80000000, 32'h404, 5'd5)) begin
            $display("FAIL srai got %h want %h", obs, pk(1'b0, 3'd5, 32'h80000000, 32'h404, 5'd5)); n_fail++;
        end
        send(32'h00435293, 32'd0, 32'h80000000, 32'd0);
        n_chk++;
        if (obs !== pk(1'b0, 3'd5, 32'h80000000, 32'h4, 5'd5)) begin
            $display("FAIL srli got %h want %h", obs, pk(1'b0, 3'd5, 32'h80000000, 32'h4, 5'd5)); n_fail++;
        end
        send(32'h40109093, 32'd0, 32'd9, 32'd0);
        n_chk++;
        if (obs !== pk(1'b1, 3'd0, 32'd0, 32'd0, 5'd1)) begin
            $display("FAIL slli_bad_imm got %h want %h", obs, pk(1'b1, 3'd0, 32'd0, 32'd0, 5'd1)); n_fail++;
        end
    endtask

    task automatic test_upper();
        send(32'h123453B7, 32'h400, 32'd55, 32'd0);
        n_chk++;
        if (obs !== pk(1'b0, 3'd0, 32'd0, 32'h12345000, 5'd7)) begin
            $display("FAIL lui got %h want %h", obs, pk(1'b0, 3'd0, 32'd0, 32'h12345000, 5'd7)); n_fail++;
        end
        send(32'h00001117, 32'h00008000, 32'd0, 32'd0);
        n_chk++;
        if (obs !== pk(1'b0, 3'd0, 32'h8000, 32'h1000, 5'd2)) begin
            $display("FAIL auipc got %h want %h", obs, pk(1'b0, 3'd0, 32'h8000, 32'h1000, 5'd2)); n_fail++;
        end
    endtask

    task automatic test_illegal();
        send(32'h0000007F, 32'h1234, 32'd1, 32'd2);
        n_chk++;
        if (obs !== pk(1'b1, 3'd0, 32'd0, 32'd0, 5'd0)) begin
            $display("FAIL illegal_opc got %h want %h", obs, pk(1'b1, 3'd0, 32'd0, 32'd0, 5'd0)); n_fail++;
        end
        // nothing new presented: the held item drains and the register empties
        @(posedge clk);
        #1;
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL drain_empty got %b want 0", bus.out_valid); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int recv = 0;
        int cyc = 0;
        logic in_f;
        logic out_f;
        logic stall_prev = 1'b0;
        logic [73:0] snap = '0;
        while ((recv < 3) && (cyc < 40)) begin
            bus.in_valid   = (sent < 3);
            bus.in_instr   = {12'(sent + 1), 5'd0, 3'd0, 5'(sent + 1), 7'b0010011};
            bus.in_pc      = 32'd0;
            bus.in_rs1_val = 32'd0;
            bus.in_rs2_val = 32'd0;
            bus.out_ready  = (cyc >= 3);
            @(negedge clk);
            in_f  = bus.in_valid && bus.in_ready;
            out_f = bus.out_valid && bus.out_ready;
            if (stall_prev) begin
                n_chk++;
                if (obs !== snap) begin
                    $display("FAIL stall_hold got %h want %h", obs, snap); n_fail++;
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            snap = obs;
            if (out_f) begin
                n_chk++;
                if (obs !== pk(1'b0, 3'd0, 32'd0, 32'(recv + 1), 5'(recv + 1))) begin
                    $display("FAIL order item %0d got %h want %h", recv, obs,
                             pk(1'b0, 3'd0, 32'd0, 32'(recv + 1), 5'(recv + 1)));
                    n_fail++;
                end
            end
            @(posedge clk);
            #1;
            if (in_f) sent++;
            if (out_f) recv++;
`ifdef ALU_DEC_SKID_EN
            if (in_f && (sent == 2)) begin
                n_chk++;
                if (bus.in_ready !== 1'b0) begin
                    $display("FAIL skid_full_ready got %b want 0", bus.in_ready); n_fail++;
                end
            end
`endif
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_chk++;
        if (recv != 3) begin
            $display("FAIL b2b_count got %0d want 3", recv); n_fail++;
        end
        n_chk++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL b2b_no_dup got %b want 0", bus.out_valid); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        send(32'h00900493, 32'd0, 32'd0, 32'd0);
        bus.out_ready = 1'b0;
        n_chk++;
        if (obs !== pk(1'b0, 3'd0, 32'd0, 32'd9, 5'd9)) begin
            $display("FAIL pre_reset_hold got %h want %h", obs, pk(1'b0, 3'd0, 32'd0, 32'd9, 5'd9)); n_fail++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== 74'd0) begin
            $display("FAIL async_reset got %h want 0", obs); n_fail++;
        end
        #10;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            $display("FAIL reset_discard got %b want 0", seen); n_fail++;
        end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_instr   = 32'd0;
        bus.in_pc      = 32'd0;
        bus.in_rs1_val = 32'd0;
        bus.in_rs2_val = 32'd0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_addi();
        test_op();
        test_imm_shift();
        test_upper();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
